ram_bist_64_8: RTL and testbench

Built-in self-test engine that drives the single-port 64x8 RAM interface (data/addr/we in, q out) as its initiator. On a start pulse it runs a three-phase march (write pattern, read-verify then write complement, descending read-verify) over all 64 locations. It reports pass/fail and captures the first failing address and read data. It sits beside the RAM and muxes onto its port while busy; the mux is outside this block.

---
 rtl/ram_bist_64_8.sv | 168 ++++++++++++++++
 tb/tb_ram_bist_64_8.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_64_8.sv
// March BIST engine for a single-port 64x8 RAM: write pattern, read/verify + write
// complement ascending, then read/verify complement descending.
module ram_bist_64_8 #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 6,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0W1,
    S_R1,
    S_R1_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic              cmp_valid_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  logic              cmp_en_c;
  logic [DATA_W-1:0] cmp_exp_c;
  logic [ADDR_W-1:0] cmp_addr_c;
  logic              mismatch_c;

  // Select which compare is live this cycle; R1 compares lag the read by one cycle.
  always_comb begin
    cmp_en_c   = 1'b0;
    cmp_exp_c  = PATTERN;
    cmp_addr_c = mem_addr_q;
    if (state_q == S_R0W1 && mem_we_q) begin
      cmp_en_c   = 1'b1;
      cmp_exp_c  = PATTERN;
      cmp_addr_c = mem_addr_q;
    end else if ((state_q == S_R1 || state_q == S_R1_DRAIN) && cmp_valid_q) begin
      cmp_en_c   = 1'b1;
      cmp_exp_c  = ~PATTERN;
      cmp_addr_c = cmp_addr_q;
    end
    mismatch_c = cmp_en_c && (mem_q != cmp_exp_c);
  end

  // March sequencer; every RAM-side and result output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      mem_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      if (mismatch_c) begin
        state_q     <= S_DONE;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        pass_q      <= 1'b0;
        mem_we_q    <= 1'b0;
        fail_addr_q <= cmp_addr_c;
        fail_data_q <= mem_q;
      end else begin
        case (state_q)
          S_IDLE: begin
            mem_we_q <= 1'b0;
            if (start) begin
              state_q     <= S_W0;
              busy_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_addr_q <= '0;
              fail_data_q <= '0;
              mem_addr_q  <= '0;
              mem_data_q  <= PATTERN;
              mem_we_q    <= 1'b1;
            end
          end
          S_W0: begin
            if (mem_addr_q == ADDR_LAST) begin
              state_q    <= S_R0W1;
              mem_addr_q <= '0;
              mem_we_q   <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
          S_R0W1: begin
            // mem_we_q low marks the read half of the address pair
            if (!mem_we_q) begin
              mem_we_q   <= 1'b1;
              mem_data_q <= ~PATTERN;
            end else if (mem_addr_q == ADDR_LAST) begin
              state_q    <= S_R1;
              mem_we_q   <= 1'b0;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
              mem_we_q   <= 1'b0;
            end
          end
          S_R1: begin
            cmp_valid_q <= 1'b1;
            cmp_addr_q  <= mem_addr_q;
            if (mem_addr_q == ADDR_ZERO) begin
              state_q <= S_R1_DRAIN;
            end else begin
              mem_addr_q <= mem_addr_q - ADDR_W'(1);
            end
          end
          S_R1_DRAIN: begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
          S_DONE: begin
            state_q  <= S_IDLE;
            mem_we_q <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            mem_we_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_data  = mem_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_ram_bist_64_8.sv
// Bench for ram_bist_64_8: two instances (PATTERN 55 and A5), each with a RAM model
// that can inject a stuck read bit or a corrupted complement write.
module tb_ram_bist_64_8;

  localparam logic [7:0] P0 = 8'h55;
  localparam logic [7:0] P1 = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic start_r;
  logic sel;

  logic       start0, busy0, done0, pass0, we0;
  logic [5:0] fa0, addr0;
  logic [7:0] fd0, md0, q0;
  logic       start1, busy1, done1, pass1, we1;
  logic [5:0] fa1, addr1;
  logic [7:0] fd1, md1, q1;

  logic       obs_busy, obs_done, obs_pass, obs_we;
  logic [5:0] obs_fa, obs_addr;
  logic [7:0] obs_fd, obs_md;

  // fault configuration shared by both RAM models
  bit         stuck_en;
  logic [5:0] stuck_a;
  logic [2:0] stuck_b;
  logic       stuck_v;
  bit         cor_en;
  logic [5:0] cor_a;
  logic [7:0] cor_v;

  logic [7:0] ram0 [64];
  logic [7:0] ram1 [64];
  logic [5:0] ar0, ar1;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  assign start0 = start_r & ~sel;
  assign start1 = start_r & sel;

  ram_bist_64_8 #(.DATA_W(8), .ADDR_W(6), .PATTERN(P0)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_addr(fa0), .fail_data(fd0), .mem_data(md0), .mem_addr(addr0), .mem_we(we0),
    .mem_q(q0)
  );

  ram_bist_64_8 #(.DATA_W(8), .ADDR_W(6), .PATTERN(P1)) u_dut_a5 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fa1), .fail_data(fd1), .mem_data(md1), .mem_addr(addr1), .mem_we(we1),
    .mem_q(q1)
  );

  // RAM models: registered address, write-first read
  always @(posedge clk) begin
    if (we0) ram0[addr0] <= (cor_en && addr0 == cor_a && md0 == ~P0) ? cor_v : md0;
    ar0 <= addr0;
    if (we1) ram1[addr1] <= (cor_en && addr1 == cor_a && md1 == ~P1) ? cor_v : md1;
    ar1 <= addr1;
  end

  always_comb begin
    q0 = ram0[ar0];
    if (stuck_en && ar0 == stuck_a) q0[stuck_b] = stuck_v;
    q1 = ram1[ar1];
    if (stuck_en && ar1 == stuck_a) q1[stuck_b] = stuck_v;
  end

  always_comb begin
    obs_busy = sel ? busy1 : busy0;
    obs_done = sel ? done1 : done0;
    obs_pass = sel ? pass1 : pass0;
    obs_we   = sel ? we1   : we0;
    obs_fa   = sel ? fa1   : fa0;
    obs_addr = sel ? addr1 : addr0;
    obs_fd   = sel ? fd1   : fd0;
    obs_md   = sel ? md1   : md0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Abstract march over an array; lat = edges from start edge to the done edge.
  function automatic void model(input logic [7:0] pat, output bit ok, output int fa,
                                output logic [7:0] fd, output int lat);
    logic [7:0] mem [64];
    logic [7:0] rd;
    ok = 1'b1; fa = 0; fd = 8'h00; lat = 257;
    for (int a = 0; a < 64; a++) mem[a] = pat;
    for (int a = 0; a < 64; a++) begin
      rd = mem[a];
      if (stuck_en && 6'(a) == stuck_a) rd[stuck_b] = stuck_v;
      if (rd != pat) begin
        ok = 1'b0; fa = a; fd = rd; lat = 66 + 2 * a;
        return;
      end
      mem[a] = (cor_en && 6'(a) == cor_a) ? cor_v : ~pat;
    end
    for (int a = 63; a >= 0; a--) begin
      rd = mem[a];
      if (stuck_en && 6'(a) == stuck_a) rd[stuck_b] = stuck_v;
      if (rd != ~pat) begin
        ok = 1'b0; fa = a; fd = rd; lat = 257 - a;
        return;
      end
    end
  endfunction

  task automatic run_test(input string tag, input int restart_at, input bit start_in_done);
    logic [7:0] pat;
    bit         ok;
    int         fa;
    logic [7:0] fd;
    int         lat;
    int         n;
    int         bcnt;
    pat = sel ? P1 : P0;
    model(pat, ok, fa, fd, lat);
    start_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    check({tag, ":busy_after_start"}, 32'(obs_busy), 32'd1);
    check({tag, ":pass_cleared"}, 32'(obs_pass), 32'd0);
    check({tag, ":fail_addr_cleared"}, 32'(obs_fa), 32'd0);
    bcnt = obs_busy ? 1 : 0;
    n = 0;
    while (!obs_done && n < 400) begin
      start_r = (n == restart_at);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (obs_busy) bcnt++;
    end
    start_r = start_in_done;
    check({tag, ":done_latency"}, 32'(n), 32'(lat));
    check({tag, ":busy_cycles"}, 32'(bcnt), 32'(lat));
    check({tag, ":busy_at_done"}, 32'(obs_busy), 32'd0);
    check({tag, ":we_at_done"}, 32'(obs_we), 32'd0);
    check({tag, ":pass"}, 32'(obs_pass), 32'(ok));
    check({tag, ":fail_addr"}, 32'(obs_fa), 32'(fa));
    check({tag, ":fail_data"}, 32'(obs_fd), 32'(fd));
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    check({tag, ":done_one_cycle"}, 32'(obs_done), 32'd0);
    check({tag, ":idle_after_done"}, 32'(obs_busy), 32'd0);
    check({tag, ":pass_held"}, 32'(obs_pass), 32'(ok));
  endtask

  task automatic check_ram_all(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 64; i++)
      check({tag, ":ram_word"}, 32'(sel ? ram1[i] : ram0[i]), 32'(exp));
  endtask

  task automatic clear_faults();
    stuck_en = 1'b0; stuck_a = '0; stuck_b = '0; stuck_v = 1'b0;
    cor_en = 1'b0; cor_a = '0; cor_v = '0;
  endtask

  initial begin
    bit seen;
    int kind;
    rst = 1'b1; start_r = 1'b0; sel = 1'b0;
    clear_faults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:busy", 32'(obs_busy), 32'd0);
    check("reset:done", 32'(obs_done), 32'd0);
    check("reset:pass", 32'(obs_pass), 32'd0);
    check("reset:fail_addr", 32'(obs_fa), 32'd0);
    check("reset:fail_data", 32'(obs_fd), 32'd0);
    check("reset:mem_data", 32'(obs_md), 32'd0);
    check("reset:mem_addr", 32'(obs_addr), 32'd0);
    check("reset:mem_we", 32'(obs_we), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle:mem_we", 32'(obs_we), 32'd0);

    run_test("clean55", -1, 1'b0);
    check_ram_all("clean55", 8'hAA);

    stuck_en = 1'b1; stuck_a = 6'h05; stuck_b = 3'd0; stuck_v = 1'b1;
    run_test("stuck1_a05", -1, 1'b0);
    stuck_v = 1'b0;
    run_test("stuck0_a05", -1, 1'b0);
    clear_faults();

    cor_en = 1'b1; cor_a = 6'h3E; cor_v = 8'h00;
    run_test("corrupt_a3e", -1, 1'b0);
    clear_faults();

    repeat (2) @(negedge clk);
    run_test("restart_ignored", 99, 1'b1);

    // reset in the middle of R0W1
    start_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset:busy", 32'(obs_busy), 32'd0);
    check("midreset:mem_we", 32'(obs_we), 32'd0);
    check("midreset:done", 32'(obs_done), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (obs_done) seen = 1'b1;
    end
    check("midreset:no_done", 32'(seen), 32'd0);
    run_test("after_reset", -1, 1'b0);
    check_ram_all("after_reset", 8'hAA);

    // A5 instance, back-to-back starts
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_test("a5_first", -1, 1'b0);
    run_test("a5_back2back", -1, 1'b0);
    check_ram_all("a5_back2back", 8'h5A);

    // randomized fault campaign on both instances
    for (int t = 0; t < 10; t++) begin
      clear_faults();
      sel  = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      if (kind == 1) begin
        stuck_en = 1'b1;
        stuck_a  = 6'($urandom_range(0, 63));
        stuck_b  = 3'($urandom_range(0, 7));
        stuck_v  = 1'($urandom_range(0, 1));
      end else if (kind == 2) begin
        cor_en = 1'b1;
        cor_a  = 6'($urandom_range(0, 63));
        cor_v  = 8'($urandom_range(0, 255));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_test($sformatf("rand%0d_k%0d", t, kind), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
